// File: rtl/layer_conv_seq_pkg.sv
// Shared definitions for the sequential convolution layer: default data
// geometry, FSM state encoding and single-bit ON/OFF constants.
package layer_conv_seq_pkg;

   localparam int unsigned BIT_DATA = 8;
   localparam int unsigned KSIZE    = 9;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_POST = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

endpackage

// File: rtl/conv_lane_dot.sv
// Combinational signed KSIZE-tap dot product for one output-channel lane.
// Ports:
//   i_x     - KSIZE signed taps of one input channel
//   i_w     - KSIZE signed weights of the same input channel
//   o_dot_c - full-precision signed sum of the KSIZE products
module conv_lane_dot #(
   parameter int unsigned BIT_DATA = layer_conv_seq_pkg::BIT_DATA,
   parameter int unsigned KSIZE    = layer_conv_seq_pkg::KSIZE
) (
   input  logic        [KSIZE*BIT_DATA-1:0]             i_x,
   input  logic        [KSIZE*BIT_DATA-1:0]             i_w,
   output logic signed [2*BIT_DATA+$clog2(KSIZE)-1:0]   o_dot_c
);

   localparam int unsigned BIT_PROD = 2 * BIT_DATA;
   localparam int unsigned BIT_DOT  = 2 * BIT_DATA + $clog2(KSIZE);

   logic signed [BIT_PROD-1:0] w_a    [KSIZE];
   logic signed [BIT_PROD-1:0] w_b    [KSIZE];
   logic signed [BIT_PROD-1:0] w_prod [KSIZE];

   // Operands are sign-extended before the multiply so the product is exact.
   always_comb begin
      o_dot_c = '0;
      for (int t = 0; t < int'(KSIZE); t++) begin
         w_a[t]    = BIT_PROD'($signed(i_x[t*BIT_DATA +: BIT_DATA]));
         w_b[t]    = BIT_PROD'($signed(i_w[t*BIT_DATA +: BIT_DATA]));
         w_prod[t] = w_a[t] * w_b[t];
         o_dot_c   = o_dot_c + BIT_DOT'(w_prod[t]);
      end
   end

endmodule

// File: rtl/layer_conv_seq.sv
// Time-multiplexed convolution layer: LANES output channels are computed in
// parallel and reused over FILTER_OUT/LANES groups, one input channel per
// cycle, followed by a shift/saturate/ReLU step per group.
// Ports:
//   clock, reset          - clock, asynchronous active-low reset
//   w_we/w_addr/w/w_ready - weight bank write (accepted only in IDLE)
//   x/scale/x_valid/x_ready - input window and its right-shift amount
//   z/z_valid/z_ready     - result vector, held until handshake
//   skipped               - result came from an all-zero window
module layer_conv_seq #(
   parameter int unsigned FILTER_IN  = 8,
   parameter int unsigned FILTER_OUT = 16,
   parameter int unsigned LANES      = 4,
   parameter int unsigned BIT_DATA   = layer_conv_seq_pkg::BIT_DATA,
   parameter int unsigned KSIZE      = layer_conv_seq_pkg::KSIZE,
   parameter int unsigned BIT_SCALE  = 4,
   parameter int unsigned RELU_EN    = 1
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  w_we,
   input  logic [$clog2(FILTER_OUT)-1:0]         w_addr,
   input  logic [FILTER_IN*KSIZE*BIT_DATA-1:0]   w,
   output logic                                  w_ready,
   input  logic [FILTER_IN*KSIZE*BIT_DATA-1:0]   x,
   input  logic [BIT_SCALE-1:0]                  scale,
   input  logic                                  x_valid,
   output logic                                  x_ready,
   output logic [FILTER_OUT*BIT_DATA-1:0]        z,
   output logic                                  z_valid,
   input  logic                                  z_ready,
   output logic                                  skipped
);

   import layer_conv_seq_pkg::*;

   localparam int unsigned NG      = FILTER_OUT / LANES;
   localparam int unsigned ROW     = KSIZE * BIT_DATA;
   localparam int unsigned BIT_W   = FILTER_IN * ROW;
   localparam int unsigned BIT_AW  = $clog2(FILTER_OUT);
   localparam int unsigned BIT_DOT = 2 * BIT_DATA + $clog2(KSIZE);
   localparam int unsigned BIT_ACC = 2 * BIT_DATA + $clog2(KSIZE * FILTER_IN);
   localparam int unsigned BIT_IC  = (FILTER_IN > 1) ? $clog2(FILTER_IN) : 1;
   localparam int unsigned BIT_OG  = (NG > 1) ? $clog2(NG) : 1;

   localparam logic signed [BIT_ACC-1:0] SAT_MAX = BIT_ACC'((2 ** (BIT_DATA - 1)) - 1);
   localparam logic signed [BIT_ACC-1:0] SAT_MIN = ~SAT_MAX;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [BIT_W-1:0]            r_bank [FILTER_OUT];
   logic [BIT_W-1:0]            r_x;
   logic [BIT_SCALE-1:0]        r_scale;
   logic [BIT_IC-1:0]           r_ic;
   logic [BIT_OG-1:0]           r_og;
   logic signed [BIT_ACC-1:0]   r_acc [LANES];
   logic [FILTER_OUT*BIT_DATA-1:0] r_z;
   logic                        r_z_valid;
   logic                        r_skipped;

   logic                        w_x_ready;
   logic                        w_w_ready;
   logic                        w_accept;
   logic                        w_x_zero;
   logic                        w_last_ic;
   logic                        w_last_og;
   logic [BIT_AW-1:0]           w_ch    [LANES];
   logic [ROW-1:0]              w_row_x;
   logic [ROW-1:0]              w_row_w [LANES];
   logic signed [BIT_DOT-1:0]   w_dot   [LANES];
   logic signed [BIT_ACC-1:0]   w_shift [LANES];
   logic [BIT_DATA-1:0]         w_post  [LANES];

   assign w_x_zero  = (x == '0);
   assign w_last_ic = (r_ic == BIT_IC'(FILTER_IN - 1));
   assign w_last_og = (r_og == BIT_OG'(NG - 1));

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and handshake readies; a weight write blocks window accept.
   always_comb begin
      w_state_nxt = r_state;
      w_x_ready   = OFF;
      w_w_ready   = OFF;
      w_accept    = OFF;
      unique case (r_state)
         ST_IDLE: begin
            w_w_ready = ON;
            w_x_ready = !w_we;
            if (x_valid && !w_we) begin
               w_accept    = ON;
               w_state_nxt = w_x_zero ? ST_OUT : ST_MAC;
            end
         end
         ST_MAC:  if (w_last_ic) w_state_nxt = ST_POST;
         ST_POST: w_state_nxt = w_last_og ? ST_OUT : ST_MAC;
         ST_OUT:  if (z_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand selection for the current input channel and output group.
   always_comb begin
      w_row_x = r_x[int'(r_ic)*ROW +: ROW];
      for (int l = 0; l < int'(LANES); l++) begin
         w_ch[l]    = BIT_AW'(int'(r_og) * int'(LANES) + l);
         w_row_w[l] = r_bank[w_ch[l]][int'(r_ic)*ROW +: ROW];
      end
   end

   for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
      conv_lane_dot #(
         .BIT_DATA (BIT_DATA),
         .KSIZE    (KSIZE)
      ) u_dot (
         .i_x     (w_row_x),
         .i_w     (w_row_w[l]),
         .o_dot_c (w_dot[l])
      );
   end

   // Arithmetic shift, saturate to the data range, then optional ReLU.
   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         w_shift[l] = r_acc[l] >>> r_scale;
         if (w_shift[l] > SAT_MAX)      w_post[l] = SAT_MAX[BIT_DATA-1:0];
         else if (w_shift[l] < SAT_MIN) w_post[l] = SAT_MIN[BIT_DATA-1:0];
         else                           w_post[l] = w_shift[l][BIT_DATA-1:0];
         if (RELU_EN != 0 && w_shift[l][BIT_ACC-1]) w_post[l] = '0;
      end
   end

   // Datapath: weight banks, captured window, counters, accumulators, result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(FILTER_OUT); i++) r_bank[i] <= '0;
         for (int l = 0; l < int'(LANES); l++)      r_acc[l]  <= '0;
         r_x       <= '0;
         r_scale   <= '0;
         r_ic      <= '0;
         r_og      <= '0;
         r_z       <= '0;
         r_z_valid <= OFF;
         r_skipped <= OFF;
      end else begin
         r_z_valid <= (w_state_nxt == ST_OUT);
         if (r_state == ST_IDLE && w_we) r_bank[w_addr] <= w;
         if (w_accept) begin
            r_x       <= x;
            r_scale   <= scale;
            r_skipped <= w_x_zero;
            r_ic      <= '0;
            r_og      <= '0;
            for (int l = 0; l < int'(LANES); l++) r_acc[l] <= '0;
            if (w_x_zero) r_z <= '0;
         end
         if (r_state == ST_MAC) begin
            for (int l = 0; l < int'(LANES); l++)
               r_acc[l] <= r_acc[l] + BIT_ACC'(w_dot[l]);
            if (!w_last_ic) r_ic <= r_ic + BIT_IC'(1);
         end
         if (r_state == ST_POST) begin
            for (int l = 0; l < int'(LANES); l++) begin
               r_z[int'(w_ch[l])*BIT_DATA +: BIT_DATA] <= w_post[l];
               r_acc[l] <= '0;
            end
            r_ic <= '0;
            if (!w_last_og) r_og <= r_og + BIT_OG'(1);
         end
      end
   end

   assign w_ready = w_w_ready;
   assign x_ready = w_x_ready;
   assign z       = r_z;
   assign z_valid = r_z_valid;
   assign skipped = r_skipped;

endmodule

// File: tb/tb_layer_conv_seq.sv
// Scoreboard bench for layer_conv_seq: two instances (ReLU on / off) share
// all inputs; expected results come from an integer reference model.
module tb_layer_conv_seq;

   localparam int FI = 8;
   localparam int FO = 16;
   localparam int KS = 9;

   logic         clock;
   logic         reset;
   logic         w_we;
   logic [3:0]   w_addr;
   logic [575:0] w;
   logic [575:0] x;
   logic [3:0]   scale;
   logic         x_valid;
   logic         z_ready;

   logic         w_ready_a, x_ready_a, z_valid_a, skipped_a;
   logic [127:0] z_a;
   logic         w_ready_b, x_ready_b, z_valid_b, skipped_b;
   logic [127:0] z_b;

   layer_conv_seq #(.RELU_EN(1)) u_dut_relu (
      .clock(clock), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w(w),
      .w_ready(w_ready_a), .x(x), .scale(scale), .x_valid(x_valid),
      .x_ready(x_ready_a), .z(z_a), .z_valid(z_valid_a), .z_ready(z_ready),
      .skipped(skipped_a));

   layer_conv_seq #(.RELU_EN(0)) u_dut_lin (
      .clock(clock), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w(w),
      .w_ready(w_ready_b), .x(x), .scale(scale), .x_valid(x_valid),
      .x_ready(x_ready_b), .z(z_b), .z_valid(z_valid_b), .z_ready(z_ready),
      .skipped(skipped_b));

   typedef struct {
      logic [127:0] z_relu;
      logic [127:0] z_lin;
      logic         skip;
      int           lat;
      int           acc_cyc;
   } exp_t;

   exp_t q[$];
   int   wt [FO][FI][KS];
   int   xs [FI][KS];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   zr_hold = 0;
   bit   zr_rand = 0;

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Reference: direct sum over channels and taps, then shift/clamp/ReLU.
   function automatic logic [127:0] model(input int sc, input bit relu);
      logic [127:0] r;
      int acc;
      int s;
      r = '0;
      for (int o = 0; o < FO; o++) begin
         acc = 0;
         for (int c = 0; c < FI; c++)
            for (int t = 0; t < KS; t++)
               acc += xs[c][t] * wt[o][c][t];
         s = acc >>> sc;
         if (s > 127)  s = 127;
         if (s < -128) s = -128;
         if (relu && s < 0) s = 0;
         r[o*8 +: 8] = 8'(s);
      end
      return r;
   endfunction

   function automatic bit x_is_zero();
      for (int c = 0; c < FI; c++)
         for (int t = 0; t < KS; t++)
            if (xs[c][t] != 0) return 0;
      return 1;
   endfunction

   function automatic logic [575:0] pack_x();
      logic [575:0] v;
      for (int c = 0; c < FI; c++)
         for (int t = 0; t < KS; t++)
            v[(c*KS+t)*8 +: 8] = 8'(xs[c][t]);
      return v;
   endfunction

   function automatic logic [575:0] pack_w(input int o);
      logic [575:0] v;
      for (int c = 0; c < FI; c++)
         for (int t = 0; t < KS; t++)
            v[(c*KS+t)*8 +: 8] = 8'(wt[o][c][t]);
      return v;
   endfunction

   function automatic exp_t make_exp(input int sc);
      exp_t e;
      e.z_relu  = model(sc, 1);
      e.z_lin   = model(sc, 0);
      e.skip    = x_is_zero();
      e.lat     = e.skip ? 0 : 36;
      e.acc_cyc = 0;
      return e;
   endfunction

   task automatic fill_w(input int v);
      for (int o = 0; o < FO; o++)
         for (int c = 0; c < FI; c++)
            for (int t = 0; t < KS; t++)
               wt[o][c][t] = v;
   endtask

   task automatic fill_x(input int v);
      for (int c = 0; c < FI; c++)
         for (int t = 0; t < KS; t++)
            xs[c][t] = v;
   endtask

   task automatic write_all();
      for (int o = 0; o < FO; o++) begin
         @(posedge clock); #1;
         w_we   = 1;
         w_addr = 4'(o);
         w      = pack_w(o);
         @(posedge clock); #1;
         w_we   = 0;
      end
   endtask

   task automatic send_window(input int sc, input bit expect_done);
      exp_t e;
      bit got;
      e = make_exp(sc);
      @(posedge clock); #1;
      x       = pack_x();
      scale   = 4'(sc);
      x_valid = 1;
      got     = 0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clock);
         if (x_ready_a) begin
            got = 1;
            e.acc_cyc = cyc + 1;
            if (expect_done) q.push_back(e);
         end
      end
      if (!got) fail_now("accept");
      @(posedge clock); #1;
      x_valid = 0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 600 && q.size() != 0; n++) @(negedge clock);
      if (q.size() != 0) begin
         fail_now("drain");
         q.delete();
      end
   endtask

   initial begin
      z_ready = 1;
      forever begin
         @(posedge clock); #1;
         z_ready = zr_hold ? 1'b0 : (zr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Monitor: latency on each z_valid rise, full compare on each handshake.
   initial begin
      exp_t e;
      bit prev_zv;
      prev_zv = 0;
      forever begin
         @(negedge clock);
         if (!reset) prev_zv = 0;
         else begin
            if (z_valid_a && !prev_zv) begin
               if (q.size() == 0) fail_now("unexpected_z_valid");
               else check_int("latency", cyc - q[0].acc_cyc, q[0].lat);
            end
            if (z_valid_a && z_ready && q.size() != 0) begin
               e = q.pop_front();
               check("z_relu", z_a, e.z_relu);
               check("z_lin", z_b, e.z_lin);
               check("skipped_relu", 128'(skipped_a), 128'(e.skip));
               check("skipped_lin", 128'(skipped_b), 128'(e.skip));
               check("z_valid_lin", 128'(z_valid_b), 128'(1'b1));
            end
            prev_zv = z_valid_a;
         end
      end
   end

   initial begin
      bit got;
      reset = 0; w_we = 0; w_addr = '0; w = '0; x = '0; scale = '0; x_valid = 0;
      fill_w(0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_z", z_a, '0);
      check("rst_z_valid", 128'(z_valid_a), '0);
      check("rst_skipped", 128'(skipped_a), '0);
      reset = 1;
      @(negedge clock);
      check("idle_x_ready", 128'(x_ready_a), 128'(1'b1));
      check("idle_w_ready", 128'(w_ready_a), 128'(1'b1));

      // Banks are zero after reset.
      fill_x(1);
      send_window(0, 1); wait_done();

      // Identity: 72 products of 1.
      fill_w(1); write_all();
      fill_x(1);
      send_window(0, 1); wait_done();

      // Saturation and ReLU.
      fill_w(127); write_all();
      fill_x(-128);
      send_window(0, 1); wait_done();
      fill_x(127);
      send_window(4, 1); wait_done();

      // Shift of a single +/-100 product.
      fill_w(0);
      wt[5][2][3] = 10;
      wt[6][2][3] = -10;
      write_all();
      fill_x(0);
      xs[2][3] = 10;
      send_window(2, 1); wait_done();

      // Early termination, then a normal window.
      fill_x(0);
      send_window(0, 1); wait_done();
      xs[2][3] = 10;
      send_window(2, 1); wait_done();

      // Reset mid-window.
      fill_w(1); write_all();
      fill_x(1);
      send_window(0, 0);
      repeat (10) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      check("midrst_z", z_a, '0);
      check("midrst_z_valid", 128'(z_valid_a), '0);
      reset = 1;
      fill_w(0);
      @(negedge clock);
      check("midrst_x_ready", 128'(x_ready_a), 128'(1'b1));
      send_window(0, 1); wait_done();

      // Backpressure: z held, writes ignored outside IDLE.
      for (int o = 0; o < FO; o++)
         for (int c = 0; c < FI; c++)
            for (int t = 0; t < KS; t++)
               wt[o][c][t] = int'($urandom_range(0, 40)) - 20;
      write_all();
      for (int c = 0; c < FI; c++)
         for (int t = 0; t < KS; t++)
            xs[c][t] = int'($urandom_range(0, 255)) - 128;
      zr_hold = 1;
      send_window(3, 1);
      got = 0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clock);
         got = z_valid_a;
      end
      if (!got) fail_now("hold_z_valid");
      for (int n = 0; n < 20; n++) begin
         @(posedge clock); #1;
         w_we = 1; w_addr = 4'd7; w = {18{32'hdeadbeef}};
         @(negedge clock);
         if (q.size() != 0) check("hold_z", z_a, q[0].z_relu);
         check("hold_x_ready", 128'(x_ready_a), '0);
         check("hold_w_ready", 128'(w_ready_a), '0);
      end
      @(posedge clock); #1;
      w_we = 0;
      zr_hold = 0;
      wait_done();

      // Simultaneous write and window in IDLE: write wins, accept follows.
      @(posedge clock); #1;
      for (int c = 0; c < FI; c++)
         for (int t = 0; t < KS; t++) begin
            wt[3][c][t] = int'($urandom_range(0, 40)) - 20;
            xs[c][t]    = int'($urandom_range(0, 255)) - 128;
         end
      w_we = 1; w_addr = 4'd3; w = pack_w(3);
      x = pack_x(); scale = 4'd2; x_valid = 1;
      @(negedge clock);
      check("simul_x_ready", 128'(x_ready_a), '0);
      check("simul_w_ready", 128'(w_ready_a), 128'(1'b1));
      @(posedge clock); #1;
      w_we = 0;
      @(negedge clock);
      check("simul_accept_next", 128'(x_ready_a), 128'(1'b1));
      begin
         exp_t e;
         e = make_exp(2);
         e.acc_cyc = cyc + 1;
         q.push_back(e);
      end
      @(posedge clock); #1;
      x_valid = 0;
      wait_done();

      // Random windows with random backpressure.
      zr_rand = 1;
      for (int k = 0; k < 8; k++) begin
         for (int o = 0; o < FO; o++)
            for (int c = 0; c < FI; c++)
               for (int t = 0; t < KS; t++)
                  wt[o][c][t] = int'($urandom_range(0, 255)) - 128;
         write_all();
         if ($urandom_range(0, 4) == 0) fill_x(0);
         else
            for (int c = 0; c < FI; c++)
               for (int t = 0; t < KS; t++)
                  xs[c][t] = int'($urandom_range(0, 255)) - 128;
         send_window(int'($urandom_range(0, 15)), 1);
         wait_done();
      end
      zr_rand = 0;
      repeat (5) @(posedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
